board_ram_arbiter: RTL and testbench

Shares the single-port board-state RAM (64 squares x 4-bit piece code) between the VGA pixel pipeline and the chess game logic. The VGA port has absolute priority and a fixed read latency so the raster never glitches. The game-logic port uses a ready/valid handshake. Logic writes are posted into a small FIFO and drained in cycles the VGA port leaves idle; logic reads issue only once all earlier writes have drained.

---
 rtl/board_ram_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_board_ram_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/board_ram_arbiter.sv
// board_ram_arbiter
//   Shares the single-port board-state RAM (64 squares x 4-bit piece code)
//   between the VGA pixel pipeline and the chess game logic.
//   - VGA port: absolute priority, fixed read latency (data in the cycle
//     after the second edge following the request edge), never stalled.
//   - Logic port: ready/valid handshake. Writes are posted into a small FIFO
//     and drained in slots the VGA leaves idle. A read is held until the FIFO
//     is empty, so it always observes every earlier write.
//
// Ports
//   iCLK, iRST               clock, asynchronous active-high reset
//   iVGA_REQ/iVGA_ADDR       VGA read request and address
//   oVGA_DATA/oVGA_VALID     VGA read data, 1-cycle valid pulse
//   iL_REQ/iL_WE/iL_ADDR/iL_WDATA  logic transaction request
//   oL_READY                 transaction accepted when iL_REQ & oL_READY
//   oL_RDATA/oL_RVALID       logic read data, 1-cycle valid pulse
//   oRAM_ADDR/oRAM_WE/oRAM_WDATA   registered RAM command
//   iRAM_RDATA               RAM read data, one edge after the address
//   oBUSY                    posted writes pending or logic read outstanding
module board_ram_arbiter #(
  parameter int ADDR_W      = 6,
  parameter int DATA_W      = 4,
  parameter int WFIFO_DEPTH = 4
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iVGA_REQ,
  input  logic [ADDR_W-1:0] iVGA_ADDR,
  output logic [DATA_W-1:0] oVGA_DATA,
  output logic              oVGA_VALID,
  input  logic              iL_REQ,
  input  logic              iL_WE,
  input  logic [ADDR_W-1:0] iL_ADDR,
  input  logic [DATA_W-1:0] iL_WDATA,
  output logic              oL_READY,
  output logic [DATA_W-1:0] oL_RDATA,
  output logic              oL_RVALID,
  output logic [ADDR_W-1:0] oRAM_ADDR,
  output logic              oRAM_WE,
  output logic [DATA_W-1:0] oRAM_WDATA,
  input  logic [DATA_W-1:0] iRAM_RDATA,
  output logic              oBUSY
);

  localparam int PTR_W = $clog2(WFIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {SLOT_IDLE, SLOT_VGA, SLOT_READ, SLOT_WRITE} slot_e;
  typedef enum logic [1:0] {TAG_NONE, TAG_VGA, TAG_LOGIC} tag_e;

  // Posted-write FIFO
  logic [ADDR_W-1:0] r_fifo_addr [WFIFO_DEPTH];
  logic [DATA_W-1:0] r_fifo_data [WFIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]  r_count;

  // Read-hold register and two-stage slot tag pipeline
  logic              r_hold;
  logic [ADDR_W-1:0] r_hold_addr;
  tag_e              r_tag1, r_tag2;

  // Registered outputs
  logic [ADDR_W-1:0] r_ram_addr;
  logic              r_ram_we;
  logic [DATA_W-1:0] r_ram_wdata;
  logic [DATA_W-1:0] r_vga_data, r_l_rdata;
  logic              r_vga_valid, r_l_rvalid, r_l_ready, r_busy;

  slot_e             w_slot;
  tag_e              w_tag1_nxt;
  logic              w_accept, w_accept_rd, w_push, w_pop;
  logic              w_hold_nxt, w_inflight_nxt, w_ready_nxt, w_busy;
  logic [CNT_W-1:0]  w_count_nxt;

  // Slot arbitration: VGA, then held read (only once the FIFO is empty),
  // then FIFO head write, else idle.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned -- that is what keeps latches from being inferred.
  always_comb begin
    w_slot     = SLOT_IDLE;
    w_tag1_nxt = TAG_NONE;
    if (iVGA_REQ) begin
      w_slot     = SLOT_VGA;
      w_tag1_nxt = TAG_VGA;
    end else if (r_hold && (r_count == '0)) begin
      w_slot     = SLOT_READ;
      w_tag1_nxt = TAG_LOGIC;
    end else if (r_count != '0) begin
      w_slot     = SLOT_WRITE;
    end
  end

  assign w_accept    = iL_REQ & r_l_ready;
  assign w_accept_rd = w_accept & ~iL_WE;
  assign w_push      = w_accept & iL_WE;
  assign w_pop       = (w_slot == SLOT_WRITE);
  assign w_count_nxt = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
  assign w_hold_nxt  = (r_hold & (w_slot != SLOT_READ)) | w_accept_rd;

  // A logic read counts as in flight from its issue slot through its RVALID
  // cycle, so READY only returns in the cycle after RVALID.
  assign w_inflight_nxt = (w_tag1_nxt == TAG_LOGIC) | (r_tag1 == TAG_LOGIC) |
                          (r_tag2 == TAG_LOGIC);

  // READY is registered from the post-edge state, so during any cycle it
  // reflects the FIFO count at the start of that cycle: a full FIFO never
  // accepts a push, even if the same edge pops.
  assign w_ready_nxt = ~w_hold_nxt & ~w_inflight_nxt &
                       (w_count_nxt < CNT_W'(WFIFO_DEPTH));

  assign w_busy = (r_count != '0) | r_hold | (r_tag1 == TAG_LOGIC) |
                  (r_tag2 == TAG_LOGIC);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_hold      <= 1'b0;
      r_hold_addr <= '0;
      r_tag1      <= TAG_NONE;
      r_tag2      <= TAG_NONE;
      r_ram_addr  <= '0;
      r_ram_we    <= 1'b0;
      r_ram_wdata <= '0;
      r_vga_data  <= '0;
      r_vga_valid <= 1'b0;
      r_l_rdata   <= '0;
      r_l_rvalid  <= 1'b0;
      r_l_ready   <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);

      r_hold <= w_hold_nxt;
      if (w_accept_rd) r_hold_addr <= iL_ADDR;

      r_tag1 <= w_tag1_nxt;
      r_tag2 <= r_tag1;

      // Idle slots keep the previous address; only write slots assert WE.
      r_ram_we <= 1'b0;
      case (w_slot)
        SLOT_VGA:  r_ram_addr <= iVGA_ADDR;
        SLOT_READ: r_ram_addr <= r_hold_addr;
        SLOT_WRITE: begin
          r_ram_addr  <= r_fifo_addr[r_rd_ptr];
          r_ram_wdata <= r_fifo_data[r_rd_ptr];
          r_ram_we    <= 1'b1;
        end
        default: ;
      endcase

      // RAM data for a slot arrives one edge after its address, so the tag
      // that reached stage 2 identifies who owns iRAM_RDATA now.
      r_vga_valid <= (r_tag2 == TAG_VGA);
      if (r_tag2 == TAG_VGA) r_vga_data <= iRAM_RDATA;
      r_l_rvalid  <= (r_tag2 == TAG_LOGIC);
      if (r_tag2 == TAG_LOGIC) r_l_rdata <= iRAM_RDATA;

      r_l_ready <= w_ready_nxt;
      r_busy    <= w_busy;
    end
  end

  // NOTE: FIFO storage has no reset; r_count alone decides which entries are
  // live, so clearing the payload would cost flops for nothing.
  always_ff @(posedge iCLK) begin
    if (w_push) begin
      r_fifo_addr[r_wr_ptr] <= iL_ADDR;
      r_fifo_data[r_wr_ptr] <= iL_WDATA;
    end
  end

  assign oVGA_DATA  = r_vga_data;
  assign oVGA_VALID = r_vga_valid;
  assign oL_READY   = r_l_ready;
  assign oL_RDATA   = r_l_rdata;
  assign oL_RVALID  = r_l_rvalid;
  assign oRAM_ADDR  = r_ram_addr;
  assign oRAM_WE    = r_ram_we;
  assign oRAM_WDATA = r_ram_wdata;
  assign oBUSY      = r_busy;

endmodule

// File: tb/tb_board_ram_arbiter.sv
// Testbench for board_ram_arbiter: table-driven vectors for the VGA and
// posted-write timeline plus hand sequences for read-after-write,
// simultaneous push/pop and reset in the middle of traffic. A behavioural
// single-port RAM with one-edge read latency is attached to the RAM port.
module tb_board_ram_arbiter;

  logic       iCLK = 1'b0;
  logic       iRST = 1'b0;
  logic       iVGA_REQ = 1'b0;
  logic [5:0] iVGA_ADDR = '0;
  logic [3:0] oVGA_DATA;
  logic       oVGA_VALID;
  logic       iL_REQ = 1'b0;
  logic       iL_WE = 1'b0;
  logic [5:0] iL_ADDR = '0;
  logic [3:0] iL_WDATA = '0;
  logic       oL_READY;
  logic [3:0] oL_RDATA;
  logic       oL_RVALID;
  logic [5:0] oRAM_ADDR;
  logic       oRAM_WE;
  logic [3:0] oRAM_WDATA;
  logic [3:0] iRAM_RDATA = '0;
  logic       oBUSY;

  board_ram_arbiter #(.ADDR_W(6), .DATA_W(4), .WFIFO_DEPTH(4)) dut (
    .iCLK(iCLK), .iRST(iRST),
    .iVGA_REQ(iVGA_REQ), .iVGA_ADDR(iVGA_ADDR),
    .oVGA_DATA(oVGA_DATA), .oVGA_VALID(oVGA_VALID),
    .iL_REQ(iL_REQ), .iL_WE(iL_WE), .iL_ADDR(iL_ADDR), .iL_WDATA(iL_WDATA),
    .oL_READY(oL_READY), .oL_RDATA(oL_RDATA), .oL_RVALID(oL_RVALID),
    .oRAM_ADDR(oRAM_ADDR), .oRAM_WE(oRAM_WE), .oRAM_WDATA(oRAM_WDATA),
    .iRAM_RDATA(iRAM_RDATA), .oBUSY(oBUSY)
  );

  always #5 iCLK = ~iCLK;

  // Initial board contents: (a*7+3) mod 16, with square 5 forced to 0x9.
  function automatic logic [3:0] init_val(input int a);
    if (a == 5) return 4'h9;
    return 4'((a * 7 + 3) % 16);
  endfunction

  // RAM model: write-enable and read both use the registered address.
  logic       mem_load = 1'b1;
  logic [3:0] mem [64];
  always @(posedge iCLK) begin
    if (mem_load) begin
      for (int a = 0; a < 64; a++) mem[a] <= init_val(a);
    end else begin
      if (oRAM_WE) mem[oRAM_ADDR] <= oRAM_WDATA;
      iRAM_RDATA <= mem[oRAM_ADDR];
    end
  end

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge iCLK);
    #1;
  endtask

  task automatic l_idle();
    iL_REQ = 1'b0; iL_WE = 1'b0; iL_ADDR = '0; iL_WDATA = '0;
  endtask

  task automatic l_write(input logic [5:0] a, input logic [3:0] d);
    iL_REQ = 1'b1; iL_WE = 1'b1; iL_ADDR = a; iL_WDATA = d;
  endtask

  task automatic l_read(input logic [5:0] a);
    iL_REQ = 1'b1; iL_WE = 1'b0; iL_ADDR = a; iL_WDATA = '0;
  endtask

  task automatic check_all_zero(input string name);
    check(name, {9'd0, oVGA_DATA, oVGA_VALID, oL_READY, oL_RDATA, oL_RVALID,
                 oRAM_ADDR, oRAM_WE, oRAM_WDATA, oBUSY}, 32'd0);
  endtask

  typedef struct {
    logic       vreq;
    logic [5:0] vaddr;
    logic       lreq;
    logic       lwe;
    logic [5:0] laddr;
    logic [3:0] lwdata;
    logic       e_ready;
    logic       e_busy;
    logic       e_we;
    logic [5:0] e_raddr;
    logic [3:0] e_rwdata;
    logic       e_vvalid;
    logic [3:0] e_vdata;
  } vec_t;

  function automatic vec_t mk(input logic vreq, input logic [5:0] vaddr,
                              input logic lreq, input logic lwe,
                              input logic [5:0] laddr, input logic [3:0] lwdata,
                              input logic e_ready, input logic e_busy,
                              input logic e_we, input logic [5:0] e_raddr,
                              input logic [3:0] e_rwdata, input logic e_vvalid,
                              input logic [3:0] e_vdata);
    vec_t v;
    v.vreq = vreq; v.vaddr = vaddr; v.lreq = lreq; v.lwe = lwe;
    v.laddr = laddr; v.lwdata = lwdata; v.e_ready = e_ready; v.e_busy = e_busy;
    v.e_we = e_we; v.e_raddr = e_raddr; v.e_rwdata = e_rwdata;
    v.e_vvalid = e_vvalid; v.e_vdata = e_vdata;
    return v;
  endfunction

  localparam int NVEC = 14;
  vec_t vecs [NVEC];

  initial begin
    int  lat;
    bit  seen;
    bit  bad;

    // Outputs sampled after each edge (#1); row i's inputs are applied
    // before edge i. VGA data returns two edges after its request edge.
    //            vreq vad lreq lwe lad lwd | rdy bsy we rad rwd vv vd
    vecs[0]  = mk(1, 5, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0);
    vecs[1]  = mk(0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0);
    vecs[2]  = mk(0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 1, 4'h9);
    vecs[3]  = mk(0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0);
    vecs[4]  = mk(1, 0, 1, 1, 10, 1,  1, 0, 0, 0, 0, 0, 0);
    vecs[5]  = mk(1, 1, 1, 1, 11, 2,  1, 1, 0, 0, 0, 0, 0);
    vecs[6]  = mk(1, 2, 1, 1, 12, 3,  1, 1, 0, 0, 0, 1, 4'h3);
    vecs[7]  = mk(1, 3, 1, 1, 13, 4,  0, 1, 0, 0, 0, 1, 4'hA);
    vecs[8]  = mk(1, 4, 1, 1, 14, 5,  0, 1, 0, 0, 0, 1, 4'h1);
    vecs[9]  = mk(0, 0, 0, 0, 0, 0,   1, 1, 1, 10, 1, 1, 4'h8);
    vecs[10] = mk(0, 0, 0, 0, 0, 0,   1, 1, 1, 11, 2, 1, 4'hF);
    vecs[11] = mk(0, 0, 0, 0, 0, 0,   1, 1, 1, 12, 3, 0, 0);
    vecs[12] = mk(0, 0, 0, 0, 0, 0,   1, 1, 1, 13, 4, 0, 0);
    vecs[13] = mk(0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0);

    // ---------------- reset then idle ----------------
    #1 iRST = 1'b1;
    #1 check_all_zero("reset_async_outputs");
    step();
    step();
    check_all_zero("reset_held_outputs");
    mem_load = 1'b0;
    iRST = 1'b0;
    step();
    check("rel_ready", oL_READY, 1);
    check("rel_busy", oBUSY, 0);
    check("rel_we", oRAM_WE, 0);

    // ---------------- VGA sweep 0..63, one result per cycle ----------------
    for (int t = 0; t < 67; t++) begin
      iVGA_REQ  = (t < 64);
      iVGA_ADDR = 6'(t);
      step();
      if (t >= 2 && t < 66) begin
        check($sformatf("sweep%0d_valid", t - 2), oVGA_VALID, 1);
        check($sformatf("sweep%0d_data", t - 2), oVGA_DATA, init_val(t - 2));
      end else begin
        check($sformatf("sweep_t%0d_novalid", t), oVGA_VALID, 0);
      end
    end

    // ---------------- table: VGA latency + posted writes under VGA burst ----
    for (int i = 0; i < NVEC; i++) begin
      iVGA_REQ = vecs[i].vreq; iVGA_ADDR = vecs[i].vaddr;
      iL_REQ = vecs[i].lreq; iL_WE = vecs[i].lwe;
      iL_ADDR = vecs[i].laddr; iL_WDATA = vecs[i].lwdata;
      step();
      check($sformatf("tbl%0d_ready", i), oL_READY, vecs[i].e_ready);
      check($sformatf("tbl%0d_busy", i), oBUSY, vecs[i].e_busy);
      check($sformatf("tbl%0d_we", i), oRAM_WE, vecs[i].e_we);
      check($sformatf("tbl%0d_vvalid", i), oVGA_VALID, vecs[i].e_vvalid);
      check($sformatf("tbl%0d_rvalid", i), oL_RVALID, 0);
      if (vecs[i].e_we) begin
        check($sformatf("tbl%0d_raddr", i), oRAM_ADDR, vecs[i].e_raddr);
        check($sformatf("tbl%0d_rwdata", i), oRAM_WDATA, vecs[i].e_rwdata);
      end
      if (vecs[i].e_vvalid)
        check($sformatf("tbl%0d_vdata", i), oVGA_DATA, vecs[i].e_vdata);
    end
    for (int a = 10; a < 14; a++)
      check($sformatf("mem_after_drain_%0d", a), mem[a], 4'(a - 9));
    check("mem_rejected_write_14", mem[14], init_val(14));

    // ---------------- read-after-write ----------------
    l_write(20, 4'hC);
    step();
    check("raw_ready_after_write", oL_READY, 1);
    l_read(20);
    step();
    check("raw_ready_after_read", oL_READY, 0);
    l_idle();
    lat  = 0;
    seen = 1'b0;
    for (int n = 1; n <= 12 && !seen; n++) begin
      step();
      if (oL_RVALID) begin
        seen = 1'b1;
        lat  = n;
      end else begin
        check($sformatf("raw_ready_wait%0d", n), oL_READY, 0);
      end
    end
    check("raw_rvalid_seen", seen, 1);
    check("raw_latency", lat, 3);
    check("raw_rdata", oL_RDATA, 4'hC);
    check("raw_ready_in_rvalid", oL_READY, 0);
    step();
    check("raw_rvalid_pulse", oL_RVALID, 0);
    check("raw_ready_after", oL_READY, 1);
    check("raw_busy_after", oBUSY, 0);

    // ---------------- simultaneous push and pop at count=2 ----------------
    iVGA_REQ = 1'b1; iVGA_ADDR = 6'd0;
    l_write(30, 4'h6);
    step();
    check("pp_s1_we", oRAM_WE, 0);
    l_write(31, 4'h7);
    step();
    check("pp_s2_we", oRAM_WE, 0);
    iVGA_REQ = 1'b0;
    l_write(32, 4'h8);
    step();
    check("pp_s3_we", oRAM_WE, 1);
    check("pp_s3_cmd", {oRAM_ADDR, oRAM_WDATA}, {6'd30, 4'h6});
    check("pp_s3_ready", oL_READY, 1);
    l_idle();
    step();
    check("pp_s4_we", oRAM_WE, 1);
    check("pp_s4_cmd", {oRAM_ADDR, oRAM_WDATA}, {6'd31, 4'h7});
    step();
    check("pp_s5_we", oRAM_WE, 1);
    check("pp_s5_cmd", {oRAM_ADDR, oRAM_WDATA}, {6'd32, 4'h8});
    step();
    check("pp_s6_we", oRAM_WE, 0);
    check("pp_s6_busy", oBUSY, 0);

    // ---------------- reset with a logic read in flight ----------------
    l_read(7);
    step();
    l_idle();
    step();
    step();
    iRST = 1'b1;
    #1 check_all_zero("rst_inflight_outputs");
    step();
    iRST = 1'b0;
    bad = 1'b0;
    for (int n = 0; n < 6; n++) begin
      step();
      if (oL_RVALID || oRAM_WE) bad = 1'b1;
    end
    check("rst_inflight_no_pulse", bad, 0);
    check("rst_inflight_ready", oL_READY, 1);

    // ---------------- reset with 3 writes queued and a read held ----------
    iVGA_REQ = 1'b1; iVGA_ADDR = 6'd1;
    l_write(40, 4'hD);
    step();
    l_write(41, 4'hE);
    step();
    l_write(42, 4'hF);
    step();
    l_read(5);
    step();
    check("rstq_read_accepted", oL_READY, 0);
    check("rstq_busy", oBUSY, 1);
    iRST = 1'b1;
    iVGA_REQ = 1'b0;
    l_idle();
    #1 check_all_zero("rstq_outputs");
    step();
    step();
    iRST = 1'b0;
    bad = 1'b0;
    for (int n = 0; n < 8; n++) begin
      step();
      if (oL_RVALID || oRAM_WE) bad = 1'b1;
    end
    check("rstq_no_pulse", bad, 0);
    check("rstq_busy_after", oBUSY, 0);
    for (int a = 40; a < 43; a++)
      check($sformatf("rstq_mem_%0d", a), mem[a], init_val(a));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Global time bound so the bench always ends on its own.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

endmodule
